child_sequencer: RTL

CHILD_SEQUENCER -- requirements
Module: child_sequencer

---
 rtl/child_seq_pkg.sv | 6 +
 rtl/child_seq_timer.sv | 20 ++
 rtl/child_sequencer.sv | 82 ++++++++
 3 files changed

// File: rtl/child_seq_pkg.sv
// child_seq_pkg: shared state encoding and sizing constants for the child sequencer
package child_seq_pkg;
    localparam int DEF_N_CHILD = 5;
    localparam int IDX_W = 3;
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_LAUNCH, S_WAIT, S_FINISH} state_t;
endpackage

// File: rtl/child_seq_timer.sv
// child_seq_timer: per-child WAIT timer that saturates at its last count instead of wrapping
module child_seq_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    logic [W-1:0] r_cnt;
    assign expired = (r_cnt == LAST);
    // count WAIT cycles; holding at LAST keeps the counter from wrapping
    always_ff @(posedge clk) begin
        if (rst || clear) r_cnt <= '0;
        else if (enable && !expired) r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/child_sequencer.sv
// child_sequencer: starts each enabled child in index order and waits for its done or a timeout
module child_sequencer
    import child_seq_pkg::*;
#(
    parameter int N_CHILD = DEF_N_CHILD,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [N_CHILD-1:0] enable_mask_i,
    output logic [N_CHILD-1:0] child_start_o,
    input  logic [N_CHILD-1:0] child_done_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [N_CHILD-1:0] err_o,
    output logic [IDX_W-1:0]   cur_idx_o
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHILD);
    localparam logic [N_CHILD-1:0] ONE = 1;
    state_t r_state, w_next;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic [N_CHILD-1:0] r_mask, w_mask, r_err, w_err, w_sel;
    logic w_hit, w_expired;
    // w_sel is zero once idx reaches N_CHILD, so no out-of-range bit is ever used
    assign w_sel = ONE << r_idx;
    assign w_hit = |(child_done_i & w_sel);
    assign child_start_o = (r_state == S_LAUNCH) ? w_sel : '0;
    assign busy_o = (r_state != S_IDLE);
    assign done_o = (r_state == S_FINISH);
    assign err_o = r_err;
    assign cur_idx_o = r_idx;
    child_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state == S_LAUNCH),
        .enable  (r_state == S_WAIT),
        .expired (w_expired)
    );
    // state, index, latched mask and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx <= '0;
            r_mask <= '0;
            r_err <= '0;
        end else begin
            r_state <= w_next;
            r_idx <= w_idx;
            r_mask <= w_mask;
            r_err <= w_err;
        end
    end
    // next-state logic; a done in the timeout cycle wins over the error flag
    always_comb begin
        w_next = r_state;
        w_idx = r_idx;
        w_mask = r_mask;
        w_err = r_err;
        case (r_state)
            S_IDLE: if (start_i) begin
                w_next = S_SCAN;
                w_idx = '0;
                w_mask = enable_mask_i;
                w_err = '0;
            end
            S_SCAN: begin
                if (r_idx == LAST_IDX) w_next = S_FINISH;
                else if (|(r_mask & w_sel)) w_next = S_LAUNCH;
                else w_idx = r_idx + IDX_W'(1);
            end
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: if (w_hit || w_expired) begin
                w_next = S_SCAN;
                w_idx = r_idx + IDX_W'(1);
                if (!w_hit) w_err = r_err | w_sel;
            end
            S_FINISH: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
endmodule
